// File: rtl/rom_data_server_pkg.sv
// Shared constants for the ROM data server: default widths, table depths
// and the load/ready state encoding.
package rom_data_server_pkg;

  localparam int AW_DEF  = 8;
  localparam int DW_DEF  = 8;
  localparam int RW_DEF  = 2;
  localparam int CAW_DEF = 2;

  localparam int C_DEPTH = 1 << CAW_DEF;
  localparam int D_DEPTH = 1 << AW_DEF;

  localparam logic [15:0] REQ_CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

endpackage

// File: rtl/rom_data_server_if.sv
// Fetch bus between the data-fetch stage (master) and the ROM data server (slave).
// A request is a one-cycle ce pulse; the matching rsp_valid rises exactly one cycle later.
interface rom_data_server_if #(
  parameter int AW  = 8,
  parameter int DW  = 8,
  parameter int RW  = 2,
  parameter int CAW = 2
);
  logic           ce_rom_C;
  logic [CAW-1:0] addr_rom_C;
  logic           ce_rom_read_and_D;
  logic [AW-1:0]  addr_rom_read_and_D;
  logic [DW-1:0]  data;
  logic [DW-1:0]  d_i;
  logic [RW-1:0]  read_i;
  logic           rsp_valid_C;
  logic           rsp_valid_D;

  modport master (
    output ce_rom_C, addr_rom_C, ce_rom_read_and_D, addr_rom_read_and_D,
    input  data, d_i, read_i, rsp_valid_C, rsp_valid_D
  );

  modport slave (
    input  ce_rom_C, addr_rom_C, ce_rom_read_and_D, addr_rom_read_and_D,
    output data, d_i, read_i, rsp_valid_C, rsp_valid_D
  );
endinterface

// File: rtl/rom_data_server_rom_table_1p.sv
// Single-write / single-read synchronous table. The storage is never reset;
// only the registered read port is, and clr forces it to zero.
module rom_table_1p #(
  parameter int W     = 8,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic                     clr,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // rdata holds its value when neither re nor clr is asserted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/rom_data_server.sv
// Responder for the fetch stage: C, D and read-base tables, filled through a
// load port before the server goes READY, then read with one-cycle latency.
module rom_data_server
  import rom_data_server_pkg::*;
#(
  parameter int AW  = AW_DEF,
  parameter int DW  = DW_DEF,
  parameter int RW  = RW_DEF,
  parameter int CAW = CAW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_en,
  input  logic              ld_sel,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DW-1:0]     ld_d,
  input  logic [RW-1:0]     ld_read,
  input  logic              ld_done,
  rom_data_server_if.slave  bus,
  output logic              rsp_err,
  output logic              ld_err,
  output logic              ready,
  output logic [15:0]       req_cnt,
  output state_t            state
);

  localparam int CD = 1 << CAW;
  localparam int DD = 1 << AW;

  logic [DW-1:0] ctab [CD];

  logic serve;
  logic ld_ok;
  logic any_req;

  assign serve   = (state == READY);
  assign ld_ok   = ld_en && !serve;
  assign any_req = bus.ce_rom_C || bus.ce_rom_read_and_D;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= EMPTY;
      ready           <= 1'b0;
      ld_err          <= 1'b0;
      rsp_err         <= 1'b0;
      bus.rsp_valid_C <= 1'b0;
      bus.rsp_valid_D <= 1'b0;
      bus.data        <= '0;
      req_cnt         <= '0;
      for (int i = 0; i < CD; i++) ctab[i] <= '0;
    end else begin
      ld_err          <= ld_en && serve;
      rsp_err         <= any_req && !serve;
      bus.rsp_valid_C <= bus.ce_rom_C;
      bus.rsp_valid_D <= bus.ce_rom_read_and_D;

      // Requests outside READY still get a strobe so the requester never stalls
      if (bus.ce_rom_C) bus.data <= serve ? ctab[bus.addr_rom_C] : '0;

      if (serve && any_req && (req_cnt != REQ_CNT_MAX)) req_cnt <= req_cnt + 16'd1;

      if (ld_ok && !ld_sel) ctab[ld_addr[CAW-1:0]] <= ld_d;

      case (state)
        EMPTY: begin
          if (ld_en && ld_done) begin
            state <= READY;
            ready <= 1'b1;
          end else if (ld_en) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          if (ld_done) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        READY: begin
          ready <= 1'b1;
        end
        default: begin
          state <= EMPTY;
          ready <= 1'b0;
        end
      endcase
    end
  end

  rom_table_1p #(.W(DW), .DEPTH(DD)) u_dtab (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ld_ok && ld_sel),
    .waddr (ld_addr),
    .wdata (ld_d),
    .re    (bus.ce_rom_read_and_D && serve),
    .clr   (bus.ce_rom_read_and_D && !serve),
    .raddr (bus.addr_rom_read_and_D),
    .rdata (bus.d_i)
  );

  rom_table_1p #(.W(RW), .DEPTH(DD)) u_rtab (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ld_ok && ld_sel),
    .waddr (ld_addr),
    .wdata (ld_read),
    .re    (bus.ce_rom_read_and_D && serve),
    .clr   (bus.ce_rom_read_and_D && !serve),
    .raddr (bus.addr_rom_read_and_D),
    .rdata (bus.read_i)
  );

endmodule

// File: doc/rom_data_server.md
Name: rom_data_server

Overview:
- Responder side of the fetch interface used by the data-fetch stage.
- Holds the C table (4 x 8 bit), the D table (256 x 8 bit) and the read-base table (256 x 2 bit).
- Accepts ce/address requests from the fetch stage and returns registered data one cycle later, with a valid strobe.
- Tables are filled through a load port under a small load/ready state machine.

Parameters:
- AW, 8, D/read table address width (depth 2**AW)
- DW, 8, width of C and D entries
- RW, 2, width of read-base entries
- CAW, 2, C table address width (depth 4)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ld_en  in  1  load strobe, one entry per cycle
- ld_sel  in  1  0 = C table, 1 = D/read table
- ld_addr  in  AW  load address (C table uses the low CAW bits)
- ld_d  in  DW  value for C (ld_sel=0) or D (ld_sel=1)
- ld_read  in  RW  read-base value (ld_sel=1 only)
- ld_done  in  1  pulse: loading finished
- ce_rom_C  in  1  C table request
- addr_rom_C  in  CAW  C address
- ce_rom_read_and_D  in  1  D/read table request
- addr_rom_read_and_D  in  AW  D/read address
- data  out  DW  C table response
- d_i  out  DW  D table response
- read_i  out  RW  read-base response
- rsp_valid_C  out  1  data valid this cycle
- rsp_valid_D  out  1  d_i/read_i valid this cycle
- rsp_err  out  1  request received while not READY
- ld_err  out  1  load attempted while READY
- ready  out  1  state == READY
- req_cnt  out  16  requests served, saturating

Behaviour:
- One clock domain; all state and outputs are registered.
- Asynchronous active-low reset:
  - state = EMPTY.
  - All outputs = 0.
  - C table cleared to 0.
  - D/read arrays are not reset; their contents are undefined until loaded.
- States:
  - EMPTY: after reset. ld_en -> LOAD (that entry is written).
  - LOAD: ld_en writes one entry per cycle. ld_done -> READY. ld_en together with ld_done: the entry is written, then the state moves to READY.
  - READY: serves requests. A later ld_en is ignored, pulses ld_err for 1 cycle and writes nothing. There is no path back to EMPTY except reset.
- Request handling, READY only:
  - If ce_rom_C is high in cycle N, then in N+1: data = Ctab[addr_rom_C] and rsp_valid_C = 1.
  - ce_rom_read_and_D works the same way, independently: d_i = Dtab[addr], read_i = Rtab[addr], rsp_valid_D = 1.
  - Both ce high in the same cycle: both are served in the same cycle; no arbitration.
  - Back-to-back requests are accepted every cycle (full throughput).
  - When ce is low, the valid strobe drops to 0 and the data outputs hold their last value; the fetch stage may sample late.
- Requests in EMPTY or LOAD:
  - No read is performed and the data outputs are forced to 0.
  - rsp_valid_x = 1 and rsp_err = 1 in N+1, so the requester never hangs.
- A load write and a request to the same address in the same cycle cannot occur: loads are only accepted before READY and requests are only served in READY.
- req_cnt:
  - Increments by 1 per cycle in which at least one request is served in READY.
  - Simultaneous C and D requests count as 1.
  - Saturates at 16'hFFFF.
- Reset mid-load: contents are partially undefined and the state returns to EMPTY; the controller must reload all tables.
- ready is a registered decode of the state.

Decomposition:
- Shared constants (state encoding EMPTY=2'd0, LOAD=2'd1, READY=2'd2; table depths) go in the existing config include alongside the position codes.
- One sub-module is natural: rom_table_1p, a single-write/single-read synchronous array parameterised on width and depth. It is instantiated for the D and read-base tables.
- The C table is 4 plain registers in the top module, because it must be reset.

Test Plan:
- Reset, then request C addr 2 -> next cycle: rsp_valid_C=1, rsp_err=1, data=0, ready=0.
- Load C = {8'h00, 8'h12, 8'h2A, 8'h40}, D[5]=8'h33 with read 2'b10, then pulse ld_done -> ready=1 next cycle. Request C addr 2 and D addr 5 in the same cycle -> next cycle: data=8'h2A, d_i=8'h33, read_i=2'b10, both valids=1, req_cnt=1.
- Back-to-back D requests at addresses 5, 6, 7 over 3 cycles -> 3 consecutive valid cycles carrying the loaded values. Drop ce -> rsp_valid_D=0 and d_i holds the address-7 value.
- In READY, ld_en with D[5]=8'hFF -> ld_err pulses for 1 cycle; a subsequent read of D[5] still returns 8'h33.
- Assert rst_n low for 1 cycle mid-load -> state=EMPTY and all outputs 0 immediately (asynchronous). ld_en with ld_done in the same cycle -> entry written and ready=1 on the following cycle.
- Force req_cnt to 16'hFFFE, then issue 3 requests -> req_cnt=16'hFFFF and stays there.
